// File: rtl/uart_rx.sv
// 8N1 serial receiver with input synchronizer, mid-bit sampling and valid/frame_err pulses.
// Define UART_RX_PARITY_EN to expect an even parity bit between the data and stop bits.
//
// state  | meaning
// IDLE   | line idle, watching for a falling edge on rxs
// START  | counting to mid start bit to reject glitches
// DATA   | sampling 8 data bits, LSB first, at mid bit
// PARITY | sampling the even parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then pulsing valid or frame_err
// BREAK  | line held low after a bad stop bit, waiting for it to rise
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       uart_rx_line,
    output logic [7:0] data,
    output logic [6:0] temp,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic                   rxs_prev;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             idx;
    logic [7:0]             shift;
    logic                   frame_bad;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit;
`endif

    assign rxs  = sync[SYNC_STAGES-1];
    assign temp = data[6:0];

    always_comb begin
        frame_bad = ~rxs;
`ifdef UART_RX_PARITY_EN
        frame_bad = ~rxs | (par_bit != ^shift);
`endif
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            sync      <= '1;
            rxs_prev  <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], uart_rx_line};
            rxs_prev  <= rxs;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rxs_prev && !rxs) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        idx <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rxs;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rxs;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Leaving at mid-stop lets a start edge right at the stop-bit end be caught.
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (!frame_bad) begin
                            valid <= 1'b1;
                            data  <= shift;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            if (rxs) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= BREAK;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus random frame bench for uart_rx; expected bytes, pulse kinds and latency come from a frame-level model.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int LAT = (19 * CPB) / 2 + 3 + (PAR_EN ? CPB : 0);

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       line = 1'b1;
    logic [7:0] data;
    logic [6:0] temp;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .nRST         (nRST),
        .uart_rx_line (line),
        .data         (data),
        .temp         (temp),
        .valid        (valid),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic [7:0] d;
        logic [6:0] t;
        int         cyc;
    } ev_t;

    typedef struct {
        logic       err;
        logic [7:0] d;
        int         fall;
    } exp_t;

    ev_t        ev_q[$];
    exp_t       exp_q[$];
    int         cyc = 0;
    int         overlap = 0;
    bit         busy_seen = 1'b0;
    logic [7:0] last_good = 8'h00;
    int         n_assert = 0;
    int         n_fail = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (nRST) begin
            if (valid || frame_err) ev_q.push_back('{frame_err, data, temp, cyc});
            if (valid && frame_err) overlap++;
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; rst_bit >= 0 pulses nRST in the middle of that bit (0 = start bit).
    task automatic send(input logic [7:0] b, input logic stop, input logic pflip,
                        input int stop_len, input int rst_bit);
        logic [10:0] bits;
        int n, len, fall;
        logic ok;
        bits = '0;
        bits[8:1] = b;
        n = 9;
        if (PAR_EN) begin
            bits[9] = (^b) ^ pflip;
            n = 10;
        end
        bits[n] = stop;
        n = n + 1;
        fall = cyc;
        for (int i = 0; i < n; i++) begin
            len  = (i == n - 1) ? stop_len : CPB;
            line = bits[i];
            if (i == rst_bit) begin
                repeat (len / 2) @(negedge clk);
                nRST = 1'b0;
                @(negedge clk);
                nRST = 1'b1;
                chk("abort_data", data, 8'h00);
                chk("abort_temp", temp, 7'h00);
                chk("abort_valid", valid, 1'b0);
                chk("abort_ferr", frame_err, 1'b0);
                chk("abort_busy", busy, 1'b0);
                last_good = 8'h00;
                repeat (len - len / 2 - 1) @(negedge clk);
            end else begin
                repeat (len) @(negedge clk);
            end
        end
        line = 1'b1;
        if (rst_bit < 0) begin
            ok = stop && !(PAR_EN && pflip);
            if (ok) last_good = b;
            exp_q.push_back('{!ok, last_good, fall});
        end
    endtask

    task automatic check_events(input string tag);
        ev_t  e;
        exp_t x;
        int   d;
        chk({tag, "_count"}, ev_q.size(), exp_q.size());
        while (ev_q.size() > 0 && exp_q.size() > 0) begin
            e = ev_q.pop_front();
            x = exp_q.pop_front();
            d = e.cyc - x.fall;
            chk({tag, "_kind"}, e.err, x.err);
            chk({tag, "_data"}, e.d, x.d);
            chk({tag, "_temp"}, e.t, x.d[6:0]);
            chk({tag, "_latency"}, d, ((d >= LAT - 4) && (d <= LAT + 4)) ? d : LAT);
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        repeat (3) @(negedge clk);
        chk("rst_data", data, 8'h00);
        chk("rst_temp", temp, 7'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        nRST = 1'b1;
        idle(5);

        send(8'h48, 1'b1, 1'b0, CPB, -1);
        idle(4);
        check_events("single");
        chk("single_busy", busy, 1'b0);
        chk("single_temp_dec", temp, 7'd72);

        send(8'h48, 1'b1, 1'b0, CPB, -1);
        send(8'h38, 1'b1, 1'b0, CPB, -1);
        idle(4);
        check_events("b2b");
        chk("b2b_temp_dec", temp, 7'd56);

        busy_seen = 1'b0;
        line = 1'b0;
        repeat (4) @(negedge clk);
        idle(20);
        chk("false_busy_seen", busy_seen, 1'b1);
        chk("false_events", ev_q.size(), 0);
        chk("false_busy", busy, 1'b0);

        send(8'h55, 1'b0, 1'b0, 40, -1);
        idle(6);
        check_events("break");
        chk("break_data", data, 8'h38);
        chk("break_busy", busy, 1'b0);

        send(8'hF8 | 8'($urandom_range(0, 7)), 1'b1, 1'b0, CPB, 4);
        idle(4);
        check_events("abort");
        send(8'h2A, 1'b1, 1'b0, CPB, -1);
        idle(4);
        check_events("after_abort");
        chk("after_abort_data", data, 8'h2A);

        for (int k = 0; k < 8; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send(rb, rs, 1'b0, CPB, -1);
            idle(rs ? $urandom_range(0, 5) : 20);
        end
        idle(4);
        check_events("random");
        chk("random_busy", busy, 1'b0);

`ifdef UART_RX_PARITY_EN
        send(8'h48, 1'b1, 1'b0, CPB, -1);
        idle(4);
        check_events("par_good");
        send(8'h48, 1'b1, 1'b1, CPB, -1);
        idle(4);
        check_events("par_bad");
        chk("par_bad_busy", busy, 1'b0);
        send(8'h5A, 1'b1, 1'b0, CPB, -1);
        idle(4);
        check_events("par_after");
`endif

        chk("no_overlap", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receives 8N1 serial frames on one line and delivers each byte as a parallel word with a one-cycle valid strobe.
- Downstream consumer of the temperature UART transmitter: it decodes the transmitted temperature back into a 7-bit value.
- Used on the receiving board and as a loopback checker in simulation.
- One clock domain, 50 MHz system clock; serial input is asynchronous and is synchronized inside the block.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range >= 4.
- SYNC_STAGES, 2, flip-flops in the input synchronizer; legal range >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- nRST  input  1  synchronous active-low reset.
- uart_rx_line  input  1  serial line, idles high.
- data  output  8  last correctly received byte.
- temp  output  7  equals data[6:0].
- valid  output  1  one-cycle pulse: data/temp updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit (or parity, if enabled) was bad.
- busy  output  1  high while a frame is being received.

Behaviour:
- Reset: one clock, synchronous active-low, named clk and nRST. With nRST low at a clk edge:
  - data=0, temp=0, valid=0, frame_err=0, busy=0.
  - Synchronizer flops = 1; state = IDLE; counters = 0.
- Reset mid-frame aborts the frame silently: no valid and no frame_err.
- Synchronizer: SYNC_STAGES flops. All decisions use the synchronized line "rxs".
- Bit counter: $clog2(CLKS_PER_BIT) bits wide; it never exceeds CLKS_PER_BIT-1. Bit index is 3 bits.
- IDLE: busy=0. A falling edge of rxs (previous 1, current 0) goes to START and clears the counter. busy=1 from the next cycle.
- START: count to CLKS_PER_BIT/2 - 1, which is the mid-start-bit point.
  - rxs=1 there: false start; return to IDLE, no pulse.
  - rxs=0 there: go to DATA, clear counter and bit index.
- DATA: every CLKS_PER_BIT cycles, sample rxs into shift register bit [index], LSB first. After bit 7, go to STOP.
- STOP: sample rxs at mid-stop-bit.
  - rxs=1: next cycle valid=1, data=shift register, temp=shift[6:0]; go to IDLE.
  - rxs=0: next cycle frame_err=1, data unchanged; go to BREAK.
- BREAK: busy stays 1 until rxs=1, then IDLE. A held-low line yields exactly one frame_err.
- Latency: valid is asserted 1 cycle after the mid-stop sample, i.e. about 9.5*CLKS_PER_BIT + SYNC_STAGES + 1 cycles after the start-bit falling edge.
- Back-to-back frames: returning to IDLE at mid-stop lets a start edge that arrives at the stop-bit end be caught. Zero idle gap between frames must work.
- valid and frame_err never assert in the same cycle. Both are low in every other cycle.
- data/temp hold their value between valid pulses.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8 data bits + even parity bit + stop bit, with a PARITY state between DATA and STOP.
  - At the stop sample, parity mismatch or stop=0 gives a frame_err pulse and data is not updated.
  - Parity mismatch with stop=1 returns to IDLE, not BREAK.
  - Latency grows by CLKS_PER_BIT.
- Undefined: plain 8N1 as above; no parity logic is synthesized.

Test Plan (CLKS_PER_BIT=16):
- Send 0x48 with a clean 8N1 frame -> one valid pulse, data=0x48, temp=72, frame_err never high, busy returns to 0.
- Send 0x48 then 0x38 with zero idle gap -> two valid pulses about 160 cycles apart; data=0x48 then 0x38, temp=72 then 56.
- Line low for 4 cycles then high -> busy high briefly, no valid, no frame_err, back in IDLE.
- Send 0x55 with stop bit 0, line held low 40 cycles then high -> exactly one frame_err, data keeps previous value (0x38), busy=0 after line rises.
- Assert nRST low for 1 cycle during data bit 3 of a frame -> all outputs 0 next cycle, no pulse for that frame; next clean frame 0x2A -> valid, data=0x2A.
- UART_RX_PARITY_EN defined: 0x48 with parity 0 -> valid; 0x48 with parity 1 -> frame_err, data unchanged.
